// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_e;

  // Largest value representable in the given number of decimal digits (10^digits - 1).
  function automatic longint unsigned bcd_max_value(input int unsigned digits);
    longint unsigned v;
    v = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the next
// left shift, so that doubling it carries correctly into the next decimal digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    if (digit_i >= BCD_DIGIT_W'(5)) begin
      digit_o = digit_i + BCD_DIGIT_W'(3);
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock,
// with a start/done handshake; the result is held until the next conversion.
module binary_to_bcd
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  localparam int unsigned     BCD_W   = BCD_DIGIT_W * DIGITS;
  localparam int unsigned     CNT_W   = $clog2(WIDTH + 1);
  localparam longint unsigned BCD_MAX = bcd_max_value(DIGITS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [BCD_W-1:0] acc_adj;
  logic [BCD_W-1:0] acc_shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit_i (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The bit leaving the top digit is dropped; lower digits never depend on it,
  // which is what yields bin mod 10^DIGITS on overflow.
  assign acc_shifted = {acc_adj[BCD_W-2:0], shift_q[WIDTH-1]};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = bin;
          acc_d      = '0;
          ovf_pend_d = (64'(bin) > BCD_MAX);
          cnt_d      = CNT_W'(WIDTH);
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        acc_d   = acc_shifted;
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = acc_shifted;
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign done     = done_q;
  assign busy     = (state_q == CONVERT);

endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd: directed and random operands compared
// against an arithmetic decimal-digit model.
module tb_binary_to_bcd;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 2;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  int n_checks = 0;
  int n_fail   = 0;

  binary_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: low DIGITS decimal digits of v, packed four bits per digit.
  function automatic logic [31:0] ref_bcd(input int v);
    int m;
    int p;
    logic [31:0] r;
    p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    m = v % p;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | (32'(m % 10) << (4 * i));
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_ovf(input int v);
    int p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    return (v >= p) ? 32'd1 : 32'd0;
  endfunction

  // One full conversion; edges counts clock edges from the accepting edge (inclusive).
  task automatic run_conv(input int v, input string tag);
    int edges;
    @(negedge clk);
    start = 1'b1;
    bin   = WIDTH'(v);
    @(negedge clk);
    start = 1'b0;
    bin   = WIDTH'($urandom);
    edges = 1;
    check({tag, " busy"}, 32'(busy), 32'd1);
    while (!done && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'(WIDTH + 1));
    check({tag, " bcd"}, 32'(bcd), ref_bcd(v));
    check({tag, " ovf"}, 32'(overflow), ref_ovf(v));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " bcd_hold"}, 32'(bcd), ref_bcd(v));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int cyc;
    int last;
    int exp_v;
    logic [31:0] cap;

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check("reset bcd", 32'(bcd), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    run_conv(0, "zero");
    for (int v = 0; v < 100; v++) run_conv(v, $sformatf("sweep%0d", v));

    run_conv(100, "ovf100");
    run_conv(137, "ovf137");
    check("ovf137 const", 32'(bcd), 32'h37);
    run_conv(255, "ovf255");
    run_conv(42, "after_ovf42");
    check("after_ovf42 ovf_clear", 32'(overflow), 32'd0);

    for (int i = 0; i < 30; i++) begin
      int r;
      r = int'($urandom_range(0, 255));
      run_conv(r, $sformatf("rand%0d_%0d", i, r));
    end

    // Second start while busy must be ignored; bin change after accept has no effect.
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd25;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    bin   = 8'd63;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    cap   = '0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        ndone++;
        cap = 32'(bcd);
      end
      @(negedge clk);
    end
    check("busy_start done_count", 32'(ndone), 32'd1);
    check("busy_start bcd", cap, 32'h25);

    // Start held high: back-to-back conversions alternating 12 and 34.
    start = 1'b1;
    bin   = 8'd12;
    exp_v = 12;
    ndone = 0;
    cyc   = 0;
    last  = 0;
    while (ndone < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        check($sformatf("held bcd%0d", ndone), 32'(bcd), ref_bcd(exp_v));
        if (ndone > 0) check($sformatf("held interval%0d", ndone), 32'(cyc - last), 32'(WIDTH + 1));
        last  = cyc;
        ndone++;
        exp_v = (exp_v == 12) ? 34 : 12;
        bin   = WIDTH'(exp_v);
      end
    end
    start = 1'b0;
    check("held done_count", 32'(ndone), 32'd4);
    repeat (12) @(negedge clk);

    // Reset mid-conversion aborts without a done pulse.
    run_conv(255, "pre_reset");
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd77;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset bcd", 32'(bcd), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset ovf", 32'(overflow), 32'd0);
    ndone = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midreset no_done", 32'(ndone), 32'd0);
    run_conv(56, "post_reset56");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
